// File: rtl/alu_frame_pkg.sv
// alu_frame_pkg: shared types, constants and helpers for the ALU frame receiver
package alu_frame_pkg;
  typedef enum logic [1:0] {IDLE, PROG, RUN} rx_state_t;
  localparam int BP_SLACK = 2;
  localparam int FRAMES_W = 16;
  localparam int LEN_W = 5;
  function automatic logic [5:0] len_words(input logic [LEN_W-1:0] l);
    return l == '0 ? 6'd32 : {1'b0, l};
  endfunction
endpackage

// File: rtl/alu_frame_fifo.sv
// alu_frame_fifo: synchronous show-ahead FIFO with full/empty/count
module alu_frame_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rp];
endmodule

// File: rtl/alu_frame_rx.sv
// alu_frame_rx: programs ALU frame length, buffers ALU words and re-emits them as a tagged stream
module alu_frame_rx
  import alu_frame_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW = 32,
  parameter int LW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LW-1:0]       cfg_len,
  input  logic                cfg_len_val,
  output logic [LW-1:0]       frame_len,
  output logic                frame_len_val,
  input  logic                frame,
  input  logic [DW-1:0]       frame_data,
  output logic                frame_bp,
  output logic                out_val,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  input  logic                out_rdy,
  output logic                busy,
  output logic [FRAMES_W-1:0] frames_done,
  output logic                ovf_err,
  output logic                idle_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  rx_state_t st, st_n;
  logic [LW-1:0] cur_len, pend_len, req_len, len_m1, cnt;
  logic pend_v, req, rd, acc, last, full, empty;
  logic [CW-1:0] occ, occ_n;
  logic [DW:0] dout;
  alu_frame_fifo #(.DEPTH(DEPTH), .W(DW + 1)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(acc),
    .rd(rd),
    .din({last, frame_data}),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(occ)
  );
  assign out_val = ~empty;
  assign out_last = dout[DW];
  assign out_data = dout[DW-1:0];
  assign busy = (cnt != '0) | pend_v;
  assign len_m1 = cur_len - LW'(1);
  always_comb begin
    rd = out_val & out_rdy;
    acc = frame & (st != IDLE) & (~full | rd);
    last = cnt == len_m1;
    req = cfg_len_val | pend_v;
    req_len = cfg_len_val ? cfg_len : pend_len;
    occ_n = occ + CW'(acc) - CW'(rd);
    st_n = st == IDLE ? (cfg_len_val ? PROG : IDLE) :
           st == PROG ? RUN :
           (req & (cnt == '0)) ? PROG : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      frame_len <= '0;
      frame_len_val <= 1'b0;
      frame_bp <= 1'b1;
      cur_len <= '0;
      pend_len <= '0;
      pend_v <= 1'b0;
      cnt <= '0;
      frames_done <= '0;
      ovf_err <= 1'b0;
      idle_err <= 1'b0;
    end else begin
      st <= st_n;
      frame_len_val <= st_n == PROG;
      frame_bp <= (st_n == IDLE) | (occ_n >= CW'(DEPTH - BP_SLACK));
      if (st_n == PROG) frame_len <= req_len;
      if (st == PROG) cur_len <= frame_len;
      if (st_n == PROG) pend_v <= 1'b0;
      else if (cfg_len_val & (st != IDLE)) begin
        pend_v <= 1'b1;
        pend_len <= cfg_len;
      end
      if (acc) begin
        cnt <= last ? '0 : cnt + LW'(1);
        if (last) frames_done <= frames_done + FRAMES_W'(1);
      end
      idle_err <= idle_err | (frame & (st == IDLE));
      ovf_err <= ovf_err | (frame & (st != IDLE) & full & ~rd);
    end
  end
endmodule

// File: tb/tb_alu_frame_rx.sv
// tb_alu_frame_rx: randomized scoreboard bench for alu_frame_rx
module tb_alu_frame_rx;
  localparam int DEPTH = 8;
  localparam int DW = 32;
  localparam int LW = 5;
  logic clk = 0, rst = 0;
  logic [LW-1:0] cfg_len = '0, frame_len;
  logic cfg_len_val = 0, frame_len_val, frame = 0, frame_bp;
  logic [DW-1:0] frame_data = '0, out_data;
  logic out_val, out_last, out_rdy = 0, busy, ovf_err, idle_err;
  logic [15:0] frames_done;
  logic [DW:0] q[$];
  int checks = 0, errors = 0, mlen = 32, widx = 0, mframes = 0;
  bit armed = 0, movf = 0, midle = 0;
  alu_frame_rx #(.DEPTH(DEPTH), .DW(DW), .LW(LW)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_len(cfg_len),
    .cfg_len_val(cfg_len_val),
    .frame_len(frame_len),
    .frame_len_val(frame_len_val),
    .frame(frame),
    .frame_data(frame_data),
    .frame_bp(frame_bp),
    .out_val(out_val),
    .out_data(out_data),
    .out_last(out_last),
    .out_rdy(out_rdy),
    .busy(busy),
    .frames_done(frames_done),
    .ovf_err(ovf_err),
    .idle_err(idle_err)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic cyc();
    bit pop, acc, lst, ebp;
    int sz;
    sz = q.size();
    checks++;
    if (out_val !== (sz > 0)) begin
      errors++;
      $display("FAIL out_val: got %b expected %b", out_val, sz > 0);
    end
    pop = sz > 0 && out_rdy;
    if (pop) begin
      checks++;
      if ({out_last, out_data} !== q[0]) begin
        errors++;
        $display("FAIL out_word: got last=%b data=%h expected last=%b data=%h", out_last, out_data, q[0][DW], q[0][DW-1:0]);
      end
      q.delete(0);
    end
    acc = frame && armed && (sz < DEPTH || pop);
    if (frame && !armed) midle = 1;
    if (frame && armed && !acc) movf = 1;
    if (acc) begin
      lst = widx == mlen - 1;
      q.push_back({lst, frame_data});
      widx = lst ? 0 : widx + 1;
      if (lst) mframes++;
    end
    if (cfg_len_val) armed = 1;
    @(posedge clk);
    #1;
    ebp = !armed || q.size() >= DEPTH - 2;
    checks += 4;
    if (frames_done !== 16'(mframes)) begin
      errors++;
      $display("FAIL frames_done: got %0d expected %0d", frames_done, mframes);
    end
    if (ovf_err !== movf) begin
      errors++;
      $display("FAIL ovf_err: got %b expected %b", ovf_err, movf);
    end
    if (idle_err !== midle) begin
      errors++;
      $display("FAIL idle_err: got %b expected %b", idle_err, midle);
    end
    if (frame_bp !== ebp) begin
      errors++;
      $display("FAIL frame_bp: got %b expected %b", frame_bp, ebp);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    frame = 0;
    cfg_len_val = 0;
    out_rdy = 0;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    armed = 0;
    movf = 0;
    midle = 0;
    mframes = 0;
    widx = 0;
    mlen = 32;
  endtask
  task automatic prog(input logic [LW-1:0] len);
    cfg_len = len;
    cfg_len_val = 1;
    frame = 0;
    cyc();
    cfg_len_val = 0;
    checks++;
    if (frame_len_val !== 1'b1 || frame_len !== len) begin
      errors++;
      $display("FAIL prog_strobe: got val=%b len=%0d expected val=1 len=%0d", frame_len_val, frame_len, len);
    end
    cyc();
    checks++;
    if (frame_len_val !== 1'b0) begin
      errors++;
      $display("FAIL prog_single: frame_len_val got %b expected 0", frame_len_val);
    end
    mlen = len == 0 ? 32 : int'(len);
    widx = 0;
  endtask
  task automatic drain();
    frame = 0;
    out_rdy = 1;
    for (int i = 0; i < 4 * DEPTH && q.size() > 0; i++) cyc();
    checks++;
    if (out_val !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL drain: out_val got %b with %0d words left, expected empty", out_val, q.size());
    end
  endtask
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1;
      frame_data = $urandom;
      cyc();
    end
    frame = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({frame_len_val, frame_len, frame_bp, out_val, out_last, out_data, busy, frames_done, ovf_err, idle_err}
        !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: got val=%b len=%0d bp=%b oval=%b olast=%b odata=%h busy=%b fd=%0d ovf=%b idle=%b expected 0,0,1,0,0,0,0,0,0,0",
               frame_len_val, frame_len, frame_bp, out_val, out_last, out_data, busy, frames_done, ovf_err, idle_err);
    end
  endtask
  task automatic test_idle();
    do_reset();
    out_rdy = 1;
    send(3);
    checks++;
    if (idle_err !== 1'b1 || frame_bp !== 1'b1 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop: got idle_err=%b bp=%b out_val=%b expected 1,1,0", idle_err, frame_bp, out_val);
    end
  endtask
  task automatic test_len4();
    do_reset();
    prog(4);
    out_rdy = 1;
    send(8);
    drain();
    checks++;
    if (frames_done !== 16'd2) begin
      errors++;
      $display("FAIL len4_frames: got %0d expected 2", frames_done);
    end
  endtask
  task automatic test_len32();
    do_reset();
    prog(0);
    out_rdy = 1;
    send(32);
    drain();
    checks++;
    if (frames_done !== 16'd1) begin
      errors++;
      $display("FAIL len32_frames: got %0d expected 1", frames_done);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    prog(0);
    out_rdy = 0;
    for (int i = 1; i <= 9; i++) begin
      frame = 1;
      frame_data = $urandom;
      cyc();
      if (i == 5 || i == 6) begin
        checks++;
        if (frame_bp !== (i == 6)) begin
          errors++;
          $display("FAIL bp_rise: after word %0d got %b expected %b", i, frame_bp, i == 6);
        end
      end
    end
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", ovf_err);
    end
    drain();
  endtask
  task automatic test_reprogram();
    do_reset();
    prog(5);
    out_rdy = 1;
    send(2);
    cfg_len = 3;
    cfg_len_val = 1;
    frame = 1;
    frame_data = $urandom;
    cyc();
    cfg_len_val = 0;
    for (int i = 4; i <= 5; i++) begin
      frame = 1;
      frame_data = $urandom;
      cyc();
      checks++;
      if (frame_len_val !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reprog_wait: after word %0d got val=%b busy=%b expected 0,1", i, frame_len_val, busy);
      end
    end
    frame = 0;
    cyc();
    checks++;
    if (frame_len_val !== 1'b1 || frame_len !== 5'd3) begin
      errors++;
      $display("FAIL reprog_strobe: got val=%b len=%0d expected 1,3", frame_len_val, frame_len);
    end
    cyc();
    checks++;
    if (frame_len_val !== 1'b0) begin
      errors++;
      $display("FAIL reprog_single: got %b expected 0", frame_len_val);
    end
    mlen = 3;
    widx = 0;
    send(6);
    drain();
    checks++;
    if (frames_done !== 16'd3) begin
      errors++;
      $display("FAIL reprog_frames: got %0d expected 3", frames_done);
    end
  endtask
  task automatic test_random();
    do_reset();
    prog(LW'($urandom_range(0, 7)));
    for (int i = 0; i < 400; i++) begin
      out_rdy = ($urandom % 3) != 0;
      frame = !frame_bp && ($urandom % 4) != 0;
      frame_data = $urandom;
      cyc();
    end
    drain();
  endtask
  task automatic test_midreset();
    do_reset();
    prog(8);
    out_rdy = 0;
    send(3);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    checks++;
    if ({frame_len_val, frame_len, frame_bp, out_val, out_last, out_data, busy, frames_done, ovf_err, idle_err}
        !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_vals: got val=%b len=%0d bp=%b oval=%b olast=%b odata=%h busy=%b fd=%0d ovf=%b idle=%b expected 0,0,1,0,0,0,0,0,0,0",
               frame_len_val, frame_len, frame_bp, out_val, out_last, out_data, busy, frames_done, ovf_err, idle_err);
    end
    q.delete();
    armed = 0;
    movf = 0;
    midle = 0;
    mframes = 0;
    widx = 0;
    send(1);
    checks++;
    if (idle_err !== 1'b1) begin
      errors++;
      $display("FAIL midreset_idle: idle_err got %b expected 1", idle_err);
    end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_len4();
    test_len32();
    test_overflow();
    test_reprogram();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
